// File: rtl/lamp_tracker.sv
// lamp_tracker: observer for the thermometer-coded 16-lamp flasher bar.
// Optional macro LAMP_TRACK_STEP_CHECK_EN also flags position jumps > 1.
module lamp_tracker #(
    parameter int N_LAMP = 16,
    parameter int POS_W  = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_en,
    input  logic [N_LAMP-1:0] lamp,
    output logic [POS_W-1:0]  position,
    output logic [POS_W-1:0]  max,
    output logic [POS_W-1:0]  min,
    output logic [1:0]        dir,
    output logic              turn,
    output logic [CNT_W-1:0]  sweep_cnt,
    output logic              pattern_err,
    output logic              err_sticky
);

    // State encoding doubles as the dir output code.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_UP   = 2'b01,
        S_DOWN = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [POS_W-1:0]   max_q, max_d;
    logic [POS_W-1:0]   min_q, min_d;
    logic               turn_q, turn_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               perr_q, perr_d;
    logic               sticky_q, sticky_d;

    logic [N_LAMP:0]    lamp_x;
    logic               therm_ok;
    logic [POS_W-1:0]   k_c;
    logic               step_bad;

    // A thermometer code plus one is a power of two (or wraps to zero).
    assign lamp_x   = {1'b0, lamp};
    assign therm_ok = ((lamp_x & (lamp_x + 1'b1)) == '0);

    // Popcount gives the lamp position for a valid thermometer sample.
    always_comb begin
        k_c = '0;
        for (int i = 0; i < N_LAMP; i++) begin
            k_c = k_c + POS_W'(lamp[i]);
        end
    end

`ifdef LAMP_TRACK_STEP_CHECK_EN
    logic [POS_W-1:0] diff_c;

    // Jumps larger than one lamp are suspicious, except a drop to zero.
    always_comb begin
        diff_c   = (k_c > pos_q) ? (k_c - pos_q) : (pos_q - k_c);
        step_bad = (k_c != '0) && (diff_c > POS_W'(1));
    end
`else
    assign step_bad = 1'b0;
`endif

    // Next-state: direction FSM, turn points, sweep count and error flags.
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        max_d    = max_q;
        min_d    = min_q;
        turn_d   = 1'b0;
        cnt_d    = cnt_q;
        perr_d   = 1'b0;
        sticky_d = sticky_q;
        if (sample_en) begin
            if (!therm_ok) begin
                perr_d   = 1'b1;
                sticky_d = 1'b1;
            end else begin
                pos_d = k_c;
                if (step_bad) begin
                    perr_d   = 1'b1;
                    sticky_d = 1'b1;
                end
                case (state_q)
                    S_IDLE: begin
                        if (k_c != '0) begin
                            state_d = S_UP;
                        end
                    end
                    S_UP: begin
                        if (k_c == '0) begin
                            state_d = S_IDLE;
                            max_d   = pos_q;
                            min_d   = '0;
                            turn_d  = 1'b1;
                            cnt_d   = cnt_q + 1'b1;
                        end else if (k_c < pos_q) begin
                            state_d = S_DOWN;
                            max_d   = pos_q;
                            turn_d  = 1'b1;
                        end
                    end
                    S_DOWN: begin
                        if (k_c == '0) begin
                            state_d = S_IDLE;
                            min_d   = '0;
                            cnt_d   = cnt_q + 1'b1;
                        end else if (k_c > pos_q) begin
                            state_d = S_UP;
                            min_d   = pos_q;
                            turn_d  = 1'b1;
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pos_q    <= '0;
            max_q    <= '0;
            min_q    <= '0;
            turn_q   <= 1'b0;
            cnt_q    <= '0;
            perr_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            max_q    <= max_d;
            min_q    <= min_d;
            turn_q   <= turn_d;
            cnt_q    <= cnt_d;
            perr_q   <= perr_d;
            sticky_q <= sticky_d;
        end
    end

    assign position    = pos_q;
    assign max         = max_q;
    assign min         = min_q;
    assign dir         = state_q;
    assign turn        = turn_q;
    assign sweep_cnt   = cnt_q;
    assign pattern_err = perr_q;
    assign err_sticky  = sticky_q;

endmodule

// File: tb/tb_lamp_tracker.sv
// tb_lamp_tracker: directed checks of the lamp_tracker observer.
// Build with LAMP_TRACK_STEP_CHECK_EN to exercise the step checker.
module tb_lamp_tracker;

    logic        clk;
    logic        rst;
    logic        sample_en;
    logic [15:0] lamp;
    logic [4:0]  position;
    logic [4:0]  max;
    logic [4:0]  min;
    logic [1:0]  dir;
    logic        turn;
    logic [7:0]  sweep_cnt;
    logic        pattern_err;
    logic        err_sticky;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_cnt;

    lamp_tracker dut (
        .clk         (clk),
        .rst         (rst),
        .sample_en   (sample_en),
        .lamp        (lamp),
        .position    (position),
        .max         (max),
        .min         (min),
        .dir         (dir),
        .turn        (turn),
        .sweep_cnt   (sweep_cnt),
        .pattern_err (pattern_err),
        .err_sticky  (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of input, then settle just after the capturing edge.
    task automatic step(input logic en, input logic [15:0] l);
        @(negedge clk);
        sample_en = en;
        lamp      = l;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        sample_en = 1'b0;
        lamp      = '0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({position, max, min, dir, turn, sweep_cnt, pattern_err, err_sticky}
            !== '0) begin
            n_err++;
            $display("FAIL reset: got pos=%0d max=%0d min=%0d dir=%b cnt=%0d st=%b want all 0",
                     position, max, min, dir, sweep_cnt, err_sticky);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 8'd0;
    endtask

    task automatic test_up_down();
        logic [15:0] v;
        for (int i = 1; i <= 6; i++) begin
            v = 16'((1 << i) - 1);
            step(1'b1, v);
            n_vec++;
            if (position !== 5'(i) || dir !== 2'b01 || turn !== 1'b0) begin
                n_err++;
                $display("FAIL up_%0d: got pos=%0d dir=%b turn=%b want %0d 01 0",
                         i, position, dir, turn, i);
            end
        end
        step(1'b1, 16'h001F);
        n_vec++;
        if (position !== 5'd5 || dir !== 2'b10 || turn !== 1'b1 || max !== 5'd6) begin
            n_err++;
            $display("FAIL up_turn: got pos=%0d dir=%b turn=%b max=%0d want 5 10 1 6",
                     position, dir, turn, max);
        end
        step(1'b1, 16'h000F);
        n_vec++;
        if (position !== 5'd4 || dir !== 2'b10 || turn !== 1'b0) begin
            n_err++;
            $display("FAIL down_4: got pos=%0d dir=%b turn=%b want 4 10 0",
                     position, dir, turn);
        end
        step(1'b1, 16'h0007);
        step(1'b1, 16'h000F);
        n_vec++;
        if (position !== 5'd4 || dir !== 2'b01 || turn !== 1'b1 || min !== 5'd3) begin
            n_err++;
            $display("FAIL down_turn: got pos=%0d dir=%b turn=%b min=%0d want 4 01 1 3",
                     position, dir, turn, min);
        end
        step(1'b1, 16'h0000);
        exp_cnt++;
        n_vec++;
        if (dir !== 2'b00 || sweep_cnt !== exp_cnt || min !== 5'd0 ||
            max !== 5'd4 || turn !== 1'b1 || position !== 5'd0) begin
            n_err++;
            $display("FAIL sweep_end: got dir=%b cnt=%0d min=%0d max=%0d turn=%b want 00 %0d 0 4 1",
                     dir, sweep_cnt, min, max, turn, exp_cnt);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 16'($urandom));
            n_vec++;
            if (position !== 5'd0 || dir !== 2'b00 || sweep_cnt !== exp_cnt ||
                max !== 5'd4 || turn !== 1'b0 || pattern_err !== 1'b0) begin
                n_err++;
                $display("FAIL hold_%0d: got pos=%0d dir=%b cnt=%0d max=%0d turn=%b perr=%b",
                         i, position, dir, sweep_cnt, max, turn, pattern_err);
            end
        end
    endtask

    task automatic test_invalid();
        step(1'b1, 16'h0001);
        step(1'b1, 16'h0003);
        step(1'b1, 16'h0005);
        n_vec++;
        if (pattern_err !== 1'b1 || err_sticky !== 1'b1 ||
            position !== 5'd2 || dir !== 2'b01 || turn !== 1'b0) begin
            n_err++;
            $display("FAIL invalid: got perr=%b st=%b pos=%0d dir=%b want 1 1 2 01",
                     pattern_err, err_sticky, position, dir);
        end
        step(1'b0, 16'h0005);
        n_vec++;
        if (pattern_err !== 1'b0 || err_sticky !== 1'b1) begin
            n_err++;
            $display("FAIL invalid_pulse: got perr=%b st=%b want 0 1",
                     pattern_err, err_sticky);
        end
        step(1'b1, 16'h0003);
        n_vec++;
        if (position !== 5'd2 || dir !== 2'b01 || turn !== 1'b0) begin
            n_err++;
            $display("FAIL equal_hold: got pos=%0d dir=%b turn=%b want 2 01 0",
                     position, dir, turn);
        end
        step(1'b1, 16'h0001);
        step(1'b1, 16'h0000);
        exp_cnt++;
        n_vec++;
        if (dir !== 2'b00 || turn !== 1'b0 || sweep_cnt !== exp_cnt ||
            max !== 5'd2 || min !== 5'd0) begin
            n_err++;
            $display("FAIL down_to_idle: got dir=%b turn=%b cnt=%0d max=%0d want 00 0 %0d 2",
                     dir, turn, sweep_cnt, max, exp_cnt);
        end
    endtask

    task automatic test_full_bar();
        logic [15:0] v;
        for (int i = 1; i <= 16; i++) begin
            v = 16'((32'd1 << i) - 1);
            step(1'b1, v);
        end
        n_vec++;
        if (position !== 5'd16 || dir !== 2'b01 || pattern_err !== 1'b0) begin
            n_err++;
            $display("FAIL full_bar: got pos=%0d dir=%b perr=%b want 16 01 0",
                     position, dir, pattern_err);
        end
        step(1'b1, 16'h7FFF);
        n_vec++;
        if (max !== 5'd16 || dir !== 2'b10 || turn !== 1'b1) begin
            n_err++;
            $display("FAIL full_turn: got max=%0d dir=%b turn=%b want 16 10 1",
                     max, dir, turn);
        end
        step(1'b1, 16'h0000);
        exp_cnt++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 16'h0001);
            step(1'b1, 16'h0000);
            exp_cnt++;
            n_vec++;
            if (sweep_cnt !== exp_cnt || dir !== 2'b00) begin
                n_err++;
                $display("FAIL wrap_%0d: got cnt=%0d dir=%b want %0d 00",
                         i, sweep_cnt, dir, exp_cnt);
            end
        end
    endtask

    task automatic test_step_check();
        logic exp_perr;
`ifdef LAMP_TRACK_STEP_CHECK_EN
        exp_perr = 1'b1;
`else
        exp_perr = 1'b0;
`endif
        step(1'b1, 16'h0001);
        step(1'b1, 16'h0003);
        step(1'b1, 16'h003F);
        n_vec++;
        if (pattern_err !== exp_perr || position !== 5'd6 || dir !== 2'b01) begin
            n_err++;
            $display("FAIL step_jump: got perr=%b pos=%0d dir=%b want %b 6 01",
                     pattern_err, position, dir, exp_perr);
        end
        step(1'b1, 16'h0000);
        exp_cnt++;
        n_vec++;
        if (pattern_err !== 1'b0 || sweep_cnt !== exp_cnt) begin
            n_err++;
            $display("FAIL step_zero: got perr=%b cnt=%0d want 0 %0d",
                     pattern_err, sweep_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 16'h0001);
        step(1'b1, 16'h0003);
        @(negedge clk);
        rst       = 1'b1;
        sample_en = 1'b1;
        lamp      = 16'h0007;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({position, max, min, dir, turn, sweep_cnt, pattern_err, err_sticky}
            !== '0) begin
            n_err++;
            $display("FAIL reset_mid: got pos=%0d max=%0d dir=%b cnt=%0d st=%b want all 0",
                     position, max, dir, sweep_cnt, err_sticky);
        end
        @(negedge clk);
        rst       = 1'b0;
        sample_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_down();
        test_hold();
        test_invalid();
        test_full_bar();
        test_wrap();
        test_step_check();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
